// File: rtl/mul_carry_if.sv
// Operand/result handshake bundle for mul_carry_unit.
// product_hi is present only when MUL_HIGH_EN is defined.
interface mul_carry_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product_lo;
  logic             c_out;
  logic             z_out;
`ifdef MUL_HIGH_EN
  logic [WIDTH-1:0] product_hi;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, product_lo, c_out, z_out, product_hi
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, product_lo, c_out, z_out, product_hi
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, product_lo, c_out, z_out
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, product_lo, c_out, z_out
  );
`endif
endinterface

// File: rtl/mul_carry_unit.sv
// Iterative shift-add unsigned multiplier with exact carry/zero flags.
// Optional MUL_HIGH_EN exposes the upper product half as product_hi.
module mul_carry_unit #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  mul_carry_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mcand, acc, acc_nxt;
  logic [WIDTH-1:0] mult, mult_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             cin_r;
  logic             last;
  logic             accept;
  logic             release_res;
  logic [WIDTH-1:0] lo_r;
  logic             c_r, z_r;
`ifdef MUL_HIGH_EN
  logic [WIDTH-1:0] hi_r;
`endif

  assign accept      = (state == IDLE) && bus.in_valid;
  assign release_res = (state == DONE) && bus.out_ready;

  // One shift-add step; the 2W accumulator can never overflow.
  always_comb begin
    acc_nxt   = mult[0] ? (acc + mcand) : acc;
    mult_nxt  = mult >> 1;
    count_nxt = count + CW'(1);
    last      = (count_nxt == CW'(WIDTH)) || (EARLY_EXIT && (mult_nxt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = BUSY;
      BUSY:    if (last)        state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath and result registers; results persist after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      count <= '0;
      cin_r <= 1'b0;
      lo_r  <= '0;
      c_r   <= 1'b0;
      z_r   <= 1'b0;
`ifdef MUL_HIGH_EN
      hi_r  <= '0;
`endif
    end else if (accept) begin
      mcand <= {{WIDTH{1'b0}}, bus.a};
      acc   <= '0;
      mult  <= bus.b;
      count <= '0;
      cin_r <= bus.c_in;
    end else if (state == BUSY) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mult  <= mult_nxt;
      count <= count_nxt;
      if (last) begin
        lo_r <= acc_nxt[WIDTH-1:0];
        c_r  <= cin_r | (|acc_nxt[PW-1:WIDTH]);
        z_r  <= ~|acc_nxt[WIDTH-1:0];
`ifdef MUL_HIGH_EN
        hi_r <= acc_nxt[PW-1:WIDTH];
`endif
      end
    end
  end

  assign bus.product_lo = lo_r;
  assign bus.c_out      = c_r;
  assign bus.z_out      = z_r;
`ifdef MUL_HIGH_EN
  assign bus.product_hi = hi_r;
`endif

endmodule

// File: tb/tb_mul_carry_unit.sv
// Bench for mul_carry_unit: one EARLY_EXIT=0 and one EARLY_EXIT=1 instance driven in lockstep.
module tb_mul_carry_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic        out_ready = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_carry_if #(.WIDTH(16)) if0 ();
  mul_carry_if #(.WIDTH(16)) if1 ();

  mul_carry_unit #(.WIDTH(16), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mul_carry_unit #(.WIDTH(16), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.a = a;                assign if1.a = a;
  assign if0.b = b;                assign if1.b = b;
  assign if0.c_in = c_in;          assign if1.c_in = c_in;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  logic        ov[2], ir[2], co[2], zo[2];
  logic [15:0] lo[2];
  assign ov[0] = if0.out_valid;  assign ov[1] = if1.out_valid;
  assign ir[0] = if0.in_ready;   assign ir[1] = if1.in_ready;
  assign co[0] = if0.c_out;      assign co[1] = if1.c_out;
  assign zo[0] = if0.z_out;      assign zo[1] = if1.z_out;
  assign lo[0] = if0.product_lo; assign lo[1] = if1.product_lo;
`ifdef MUL_HIGH_EN
  logic [15:0] hi[2];
  assign hi[0] = if0.product_hi; assign hi[1] = if1.product_hi;
`endif

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Latency from the rules: fixed WIDTH, or index of b's top set bit + 1 (min 1).
  function automatic int lat_of(bit ee, logic [15:0] bv);
    int n;
    if (!ee) return 16;
    n = 1;
    for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
    return n;
  endfunction

  // Scoreboard: model each accepted op with plain arithmetic, check every valid cycle.
  initial begin
    bit          pend[2];
    bit          ov_prev[2];
    logic [15:0] e_lo[2], e_hi[2];
    logic        e_c[2], e_z[2];
    int          e_rise[2];
    logic [31:0] p;
    for (int d = 0; d < 2; d++) begin pend[d] = 0; ov_prev[d] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin pend[d] = 0; ov_prev[d] = 0; end
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (ov[d]) begin
            if (!ov_prev[d]) begin
              chk($sformatf("sb%0d_expected_op", d), 32'(pend[d]), 32'd1);
              if (pend[d]) chk($sformatf("sb%0d_rise_cycle", d), cyc, e_rise[d]);
            end
            if (pend[d]) begin
              chk($sformatf("sb%0d_lo", d), 32'(lo[d]), 32'(e_lo[d]));
              chk($sformatf("sb%0d_c", d), 32'(co[d]), 32'(e_c[d]));
              chk($sformatf("sb%0d_z", d), 32'(zo[d]), 32'(e_z[d]));
              chk($sformatf("sb%0d_in_ready", d), 32'(ir[d]), 32'd0);
`ifdef MUL_HIGH_EN
              chk($sformatf("sb%0d_hi", d), 32'(hi[d]), 32'(e_hi[d]));
`endif
            end
            if (out_ready) pend[d] = 0;
          end
          if (ir[d] && in_valid) begin
            p         = 32'(a) * 32'(b);
            e_lo[d]   = p[15:0];
            e_hi[d]   = p[31:16];
            e_c[d]    = c_in | (p >= 32'h10000);
            e_z[d]    = (p[15:0] == 16'h0);
            e_rise[d] = cyc + 1 + lat_of(d == 1, b);
            pend[d]   = 1;
          end
          ov_prev[d] = ov[d];
        end
      end
    end
  end

  // Directed op with literal expectations; caller sits just after a posedge.
  task automatic run_op(string nm, logic [15:0] ta, logic [15:0] tb, logic tc,
                        logic [15:0] elo, logic ec, logic ez, logic [15:0] ehi,
                        int l0, int l1, bit hold);
    int t0;
    int lat[2];
    in_valid = 1'b1; a = ta; b = tb; c_in = tc;
    for (int d = 0; d < 2; d++) chk($sformatf("%s_ready%0d", nm, d), 32'(ir[d]), 32'd1);
    @(posedge clk); #1;
    t0 = cyc;
    in_valid = 1'b0; a = ~ta; b = ~tb; c_in = ~tc;
    lat[0] = -1; lat[1] = -1;
    for (int k = 0; k < 40 && (lat[0] < 0 || lat[1] < 0); k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) if (ov[d] && lat[d] < 0) lat[d] = cyc - t0;
    end
    chk({nm, "_lat0"}, lat[0], l0);
    chk({nm, "_lat1"}, lat[1], l1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_lo%0d", nm, d), 32'(lo[d]), 32'(elo));
      chk($sformatf("%s_c%0d", nm, d), 32'(co[d]), 32'(ec));
      chk($sformatf("%s_z%0d", nm, d), 32'(zo[d]), 32'(ez));
`ifdef MUL_HIGH_EN
      chk($sformatf("%s_hi%0d", nm, d), 32'(hi[d]), 32'(ehi));
`else
      if (ehi === 16'hxxxx) $display("unused");
`endif
    end
    if (hold) begin
      in_valid = 1'b1; a = 16'h0007; b = 16'h0007; c_in = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("%s_hold_v%0d", nm, d), 32'(ov[d]), 32'd1);
          chk($sformatf("%s_hold_r%0d", nm, d), 32'(ir[d]), 32'd0);
          chk($sformatf("%s_hold_lo%0d", nm, d), 32'(lo[d]), 32'(elo));
        end
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_rel_v%0d", nm, d), 32'(ov[d]), 32'd0);
      chk($sformatf("%s_rel_r%0d", nm, d), 32'(ir[d]), 32'd1);
      chk($sformatf("%s_keep_lo%0d", nm, d), 32'(lo[d]), 32'(elo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), 32'(ir[d]), 32'd1);
      chk($sformatf("rst_valid%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("rst_lo%0d", d), 32'(lo[d]), 32'd0);
      chk($sformatf("rst_c%0d", d), 32'(co[d]), 32'd0);
      chk($sformatf("rst_z%0d", d), 32'(zo[d]), 32'd0);
    end
    //      name    a         b         cin   lo        c     z     hi        l0  l1  hold
    run_op("ff",   16'h00FF, 16'h0101, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16, 9,  0);
    run_op("sq",   16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 16, 9,  0);
    run_op("x3",   16'h1234, 16'h0003, 1'b0, 16'h369C, 1'b0, 1'b0, 16'h0000, 16, 2,  0);
    run_op("b0",   16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16, 1,  0);
    run_op("cin0", 16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 16, 16, 0);
    run_op("hold", 16'h0002, 16'h0003, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0000, 16, 2,  1);
    run_op("max",  16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, 16'hFFFE, 16, 16, 0);

    // Abort mid-operation with a one-edge reset.
    in_valid = 1'b1; a = 16'h1234; b = 16'hFFFF; c_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_valid%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("abort_ready%0d", d), 32'(ir[d]), 32'd1);
      chk($sformatf("abort_lo%0d", d), 32'(lo[d]), 32'd0);
      chk($sformatf("abort_c%0d", d), 32'(co[d]), 32'd0);
    end
    repeat (20) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk($sformatf("abort_quiet%0d", d), 32'(ov[d]), 32'd0);
    end
    run_op("post", 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 16'h0000, 16, 3, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_carry_unit.md
Name: mul_carry_unit

Overview:
- Iterative shift-add unsigned multiplier for the datapath ALU. Computes the full 2*WIDTH-bit product of two WIDTH-bit operands.
- Returns the low WIDTH bits plus an exact carry/overflow flag: carry-in OR'd with "high half non-zero".
- Replaces the combinational partial-product overflow predictor, which was conservative, fixed at 16 bits and had no handshake.
- Sits between the register-file read stage and the flag/write-back stage, with valid/ready on both sides.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- EARLY_EXIT, 1, 1 = terminate as soon as the remaining multiplier bits are all zero; 0 = fixed WIDTH iterations.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- c_in  input  1  incoming carry, OR'd into c_out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- product_lo  output  WIDTH  low WIDTH bits of a*b.
- c_out  output  1  c_in | (a*b >= 2^WIDTH).
- z_out  output  1  product_lo == 0.
- product_hi  output  WIDTH  high half (only with MUL_HIGH_EN).

Behaviour:
- One clock. Reset is synchronous and active-low. rst_n sampled low at a clk edge resets all state.
- Reset values:
  - state = IDLE
  - out_valid = 0
  - product_lo = 0, product_hi = 0
  - c_out = 0, z_out = 0
  - in_ready = 1 the cycle after reset.
- Reset mid-operation aborts the operation with no output.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load mcand = zero-extended a (2*WIDTH), mult = b, acc = 0 (2*WIDTH), cin_r = c_in, count = 0.
  - Go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle: if mult[0], acc <= acc + mcand (2*WIDTH wide, cannot overflow). Then mcand <<= 1, mult >>= 1, count++.
  - Leave BUSY when count reaches WIDTH, or when EARLY_EXIT=1 and the shifted mult == 0. At least one BUSY cycle always occurs.
  - On exit, register outputs from the final acc:
    - product_lo = acc[WIDTH-1:0]
    - product_hi = acc[2W-1:W]
    - c_out = cin_r | (|acc[2W-1:W])
    - z_out = ~|acc[WIDTH-1:0]
    - out_valid <= 1; go to DONE.
- DONE:
  - Outputs held stable while out_valid=1 && out_ready=0.
  - On out_ready: out_valid <= 0, go to IDLE.
  - Output regs keep their last values after the handshake.
  - No new accept in the same cycle; throughput is one op per (latency + 2) cycles minimum.
- Latency, with operands accepted at edge T:
  - out_valid rises at edge T+N.
  - N = WIDTH if EARLY_EXIT=0.
  - N = max(1, msb_index(b)+1) if EARLY_EXIT=1. b=0 gives N=1.
- Operands are sampled only at accept. a/b/c_in changes during BUSY have no effect.
- in_valid during BUSY/DONE is ignored; in_ready=0 there.
- c_in=1 forces c_out=1 regardless of the product. z_out reflects only product_lo, independent of c_in and of the high half.
- Boundary: a=b=2^WIDTH-1 gives product_hi = 2^WIDTH-2, product_lo = 1, c_out = 1.

Optional Feature:
- Macro: MUL_HIGH_EN.
- Defined: port product_hi exists and is driven as above, for the MULH instruction.
- Undefined:
  - No product_hi port.
  - Multiplier/accumulator datapath is unchanged.
  - c_out still uses the full high half internally.

Test Plan:
- WIDTH=16, EARLY_EXIT=0: a=0x00FF, b=0x0101, c_in=0 -> product_lo=0xFFFF, c_out=0, z_out=0; out_valid exactly 16 cycles after accept. With MUL_HIGH_EN: product_hi=0x0000.
- a=0x0100, b=0x0100, c_in=0 -> product_lo=0x0000, c_out=1, z_out=1, product_hi=0x0001.
- EARLY_EXIT=1:
  - a=0x1234, b=0x0003 -> product_lo=0x369C, c_out=0; out_valid 2 cycles after accept.
  - b=0x0000 -> product_lo=0, z_out=1, latency 1.
- a=0x0002, b=0x0003, c_in=1 -> product_lo=0x0006, c_out=1. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, a second in_valid ignored. Then out_ready=1 -> out_valid=0 next edge, in_ready=1.
- a=b=0xFFFF -> product_lo=0x0001, product_hi=0xFFFE, c_out=1.
- Assert rst_n=0 for one edge mid-BUSY -> next cycle out_valid=0, in_ready=1, outputs 0. A fresh op 3*5 then gives product_lo=15.
